// File: rtl/tama_pkg.sv
// Shared command codes, button-to-code mapping and encoder FSM states
// for the pet-stats command bus.
package tama_pkg;

  localparam logic [7:0] CMD_NONE   = 8'h00;
  localparam logic [7:0] CMD_EAT    = 8'h65;
  localparam logic [7:0] CMD_PLAY   = 8'h70;
  localparam logic [7:0] CMD_DOCTOR = 8'h64;
  localparam logic [7:0] CMD_BATH   = 8'h62;
  localparam logic [7:0] CMD_SLEEP  = 8'h73;
  localparam logic [7:0] CMD_TALK   = 8'h74;
  localparam logic [7:0] CMD_WAKE   = 8'h77;

  localparam int NUM_BTN = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [7:0] btn_code(input int idx);
    logic [7:0] code;
    case (idx)
      0:       code = CMD_EAT;
      1:       code = CMD_PLAY;
      2:       code = CMD_DOCTOR;
      3:       code = CMD_BATH;
      4:       code = CMD_SLEEP;
      5:       code = CMD_TALK;
      6:       code = CMD_WAKE;
      default: code = CMD_NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_legal_cmd(input logic [7:0] b);
    logic legal;
    legal = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (b == btn_code(i)) legal = 1'b1;
    end
    return legal;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability-count debouncer and
// a single-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the count.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
        press_reg <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/cmd_encoder.sv
// Arbitrates debounced buttons and UART bytes onto the command bus, holding
// each code for a fixed time followed by a mandatory zero release gap.
module cmd_encoder
  import tama_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int HOLD_CYCLES     = 16,
  parameter int GAP_CYCLES      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BTN-1:0]   btn,
  input  logic [7:0]           uart_data,
  input  logic                 uart_valid,
  output logic [7:0]           cmd,
  output logic                 busy,
  output logic                 dropped
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] btn_pend_reg, btn_pend_next, clr_btn;
  logic               uart_pend_reg, uart_pend_next, clr_uart;
  logic [7:0]         uart_byte_reg, uart_byte_next;
  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [7:0]         cmd_reg, cmd_next;
  logic               busy_reg, busy_next;
  logic               dropped_reg, dropped_next;
  logic               win_found;
  logic [7:0]         win_code;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  // Wake outranks everything, then buttons by index, then the UART slot.
  always_comb begin
    win_found = 1'b0;
    win_code  = CMD_NONE;
    clr_btn   = '0;
    clr_uart  = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (btn_pend_reg[6]) begin
        win_found  = 1'b1;
        win_code   = btn_code(6);
        clr_btn[6] = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
        if (!win_found && btn_pend_reg[i]) begin
          win_found  = 1'b1;
          win_code   = btn_code(i);
          clr_btn[i] = 1'b1;
        end
      end
      if (!win_found && uart_pend_reg) begin
        win_found = 1'b1;
        win_code  = uart_byte_reg;
        clr_uart  = 1'b1;
      end
    end
  end

  // A slot being consumed this edge counts as free, so a new set wins.
  always_comb begin
    dropped_next   = 1'b0;
    btn_pend_next  = btn_pend_reg & ~clr_btn;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (press[i]) begin
        if (btn_pend_next[i]) dropped_next = 1'b1;
        else                  btn_pend_next[i] = 1'b1;
      end
    end
    uart_pend_next = uart_pend_reg & ~clr_uart;
    uart_byte_next = uart_byte_reg;
    if (uart_valid && is_legal_cmd(uart_data)) begin
      if (uart_pend_next) begin
        dropped_next = 1'b1;
      end else begin
        uart_pend_next = 1'b1;
        uart_byte_next = uart_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cmd_next   = cmd_reg;
    case (state_reg)
      ST_IDLE: begin
        cmd_next = CMD_NONE;
        if (win_found) begin
          cmd_next   = win_code;
          cnt_next   = CW'(HOLD_CYCLES - 1);
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == '0) begin
          cmd_next   = CMD_NONE;
          cnt_next   = CW'(GAP_CYCLES - 1);
          state_next = ST_GAP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_GAP: begin
        cmd_next = CMD_NONE;
        if (cnt_reg == '0) state_next = ST_IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        cmd_next   = CMD_NONE;
      end
    endcase
    busy_next = (state_next != ST_IDLE) || (|btn_pend_next) || uart_pend_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      cmd_reg       <= CMD_NONE;
      busy_reg      <= 1'b0;
      dropped_reg   <= 1'b0;
      btn_pend_reg  <= '0;
      uart_pend_reg <= 1'b0;
      uart_byte_reg <= CMD_NONE;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cmd_reg       <= cmd_next;
      busy_reg      <= busy_next;
      dropped_reg   <= dropped_next;
      btn_pend_reg  <= btn_pend_next;
      uart_pend_reg <= uart_pend_next;
      uart_byte_reg <= uart_byte_next;
    end
  end

  assign cmd     = cmd_reg;
  assign busy    = busy_reg;
  assign dropped = dropped_reg;

endmodule

// File: tb/tb_cmd_encoder.sv
// Scoreboard bench for cmd_encoder: expected codes are queued as stimulus is
// driven and compared against command runs captured from the bus.
module tb_cmd_encoder;

  localparam int D = 4;
  localparam int H = 3;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] btn = '0;
  logic [7:0] uart_data = '0;
  logic       uart_valid = 1'b0;
  logic [7:0] cmd;
  logic       busy;
  logic       dropped;

  cmd_encoder #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .GAP_CYCLES     (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .uart_data (uart_data),
    .uart_valid(uart_valid),
    .cmd       (cmd),
    .busy      (busy),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    int         len;
    int         gap;
    int         start;
  } obs_t;

  obs_t       obs_q[$];
  logic [7:0] exp_q[$];
  int         drop_cnt = 0;
  bit         in_run = 0;
  obs_t       cur;
  int         zcnt = 0;

  // Collector: turns the cmd waveform into (code, length, preceding gap) runs.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_run = 0;
      zcnt = 0;
    end else begin
      if (dropped) drop_cnt++;
      if (cmd !== 8'h00) begin
        if (!in_run) begin
          cur.code = cmd; cur.len = 1; cur.gap = zcnt; cur.start = cyc;
          in_run = 1;
        end else begin
          cur.len++;
        end
      end else if (in_run) begin
        obs_q.push_back(cur);
        in_run = 0;
        zcnt = 1;
      end else begin
        zcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn = '0;
    uart_valid = 1'b0;
    uart_data = '0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (cmd !== 8'h00) begin tests_failed++; $display("FAIL reset_cmd: got %h want 00", cmd); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (dropped !== 1'b0) begin tests_failed++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_btn_latency();
    int k;
    obs_t o;
    logic [7:0] e;
    obs_q.delete(); exp_q.delete();
    btn[0] = 1'b1;
    k = cyc;
    exp_q.push_back(8'h65);
    wait_obs(1, 40);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL lat_count: got %0d runs want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.code !== e) begin tests_failed++; $display("FAIL lat_code: got %h want %h", o.code, e); end
      tests_run++;
      if (o.len != H) begin tests_failed++; $display("FAIL lat_len: got %0d want %0d", o.len, H); end
      tests_run++;
      if (o.start != k + 1 + D + 3) begin tests_failed++; $display("FAIL lat_start: got cycle %0d want %0d", o.start, k + 1 + D + 3); end
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (cyc >= o.start + H + G - 1) break;
      end
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL lat_busy_gap: got %b want 1", busy); end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL lat_busy_idle: got %b want 0", busy); end
      $display("[TB] btn0 code=%h len=%0d start=%0d", o.code, o.len, o.start);
    end
    #1;
    settle();
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL lat_release: got %0d extra runs want 0", obs_q.size()); end
  endtask

  task automatic test_glitch();
    bit seen_busy;
    obs_q.delete();
    seen_busy = 0;
    btn[2] = 1'b1;
    repeat (3) tick();
    btn[2] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    tests_run++;
    if (seen_busy) begin tests_failed++; $display("FAIL glitch_busy: got 1 want 0"); end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL glitch_cmd: got %0d runs want 0", obs_q.size()); end
    $display("[TB] glitch pulse runs=%0d", obs_q.size());
    tick();
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [7:0] e;
    obs_q.delete(); exp_q.delete();
    btn = 7'b1000001;
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h65);
    wait_obs(2, 80);
    tests_run++;
    if (obs_q.size() != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d runs want 2", obs_q.size()); end
    for (int n = 0; n < 2 && obs_q.size() > 0; n++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.code !== e) begin tests_failed++; $display("FAIL b2b_code%0d: got %h want %h", n, o.code, e); end
      tests_run++;
      if (o.len != H) begin tests_failed++; $display("FAIL b2b_len%0d: got %0d want %0d", n, o.len, H); end
      if (n == 1) begin
        tests_run++;
        if (o.gap != G + 1) begin tests_failed++; $display("FAIL b2b_gap: got %0d want %0d", o.gap, G + 1); end
      end
      $display("[TB] b2b code=%h len=%0d gap=%0d", o.code, o.len, o.gap);
    end
    settle();
  endtask

  task automatic test_uart();
    int k;
    obs_t o;
    logic [7:0] e;
    obs_q.delete(); exp_q.delete();
    drop_cnt = 0;
    uart_data = 8'h74; uart_valid = 1'b1;
    k = cyc;
    exp_q.push_back(8'h74);
    tick();
    uart_data = 8'h41;
    tick();
    uart_data = 8'h73;
    exp_q.push_back(8'h73);
    tick();
    uart_data = 8'h70;
    tick();
    uart_valid = 1'b0; uart_data = 8'h00;
    wait_obs(2, 60);
    tests_run++;
    if (obs_q.size() != 2) begin tests_failed++; $display("FAIL uart_count: got %0d runs want 2", obs_q.size()); end
    for (int n = 0; n < 2 && obs_q.size() > 0; n++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.code !== e) begin tests_failed++; $display("FAIL uart_code%0d: got %h want %h", n, o.code, e); end
      if (n == 0) begin
        tests_run++;
        if (o.start != k + 2) begin tests_failed++; $display("FAIL uart_latency: got cycle %0d want %0d", o.start, k + 2); end
      end
      $display("[TB] uart code=%h start=%0d", o.code, o.start);
    end
    settle();
    tests_run++;
    if (drop_cnt != 1) begin tests_failed++; $display("FAIL uart_dropped: got %0d pulse cycles want 1", drop_cnt); end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL uart_extra: got %0d runs want 0", obs_q.size()); end
  endtask

  task automatic test_btn_drop();
    obs_t o;
    logic [7:0] e;
    obs_q.delete(); exp_q.delete();
    drop_cnt = 0;
    btn = 7'b1000011;
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h65);
    exp_q.push_back(8'h70);
    repeat (4) tick();
    btn[1] = 1'b0;
    repeat (6) tick();
    btn[1] = 1'b1;
    wait_obs(3, 100);
    tests_run++;
    if (obs_q.size() != 3) begin tests_failed++; $display("FAIL drop_count: got %0d runs want 3", obs_q.size()); end
    for (int n = 0; n < 3 && obs_q.size() > 0; n++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.code !== e) begin tests_failed++; $display("FAIL drop_code%0d: got %h want %h", n, o.code, e); end
      $display("[TB] drop seq code=%h", o.code);
    end
    settle();
    tests_run++;
    if (drop_cnt != 1) begin tests_failed++; $display("FAIL drop_pulse: got %0d pulse cycles want 1", drop_cnt); end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL drop_extra: got %0d runs want 0", obs_q.size()); end
  endtask

  task automatic test_reset_hold();
    logic [7:0] e;
    bit seen;
    obs_q.delete(); exp_q.delete();
    btn[2] = 1'b1;
    exp_q.push_back(8'h64);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd === 8'h64) begin seen = 1; break; end
    end
    e = exp_q.pop_front();
    tests_run++;
    if (cmd !== e) begin tests_failed++; $display("FAIL rst_hold_code: got %h want %h", cmd, e); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (cmd !== 8'h00) begin tests_failed++; $display("FAIL rst_async_cmd: got %h want 00", cmd); end
    btn = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_q.delete();
    repeat (20) tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL rst_reappear: got %0d runs want 0", obs_q.size()); end
    $display("[TB] reset during hold seen=%0d", seen);
  endtask

  initial begin
    test_reset();
    test_btn_latency();
    test_glitch();
    test_back_to_back();
    test_uart();
    test_btn_drop();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
